fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage sitting between the PC and decode.
//
// Owns the fetch PC and drives the instruction-memory read address every cycle.
// The memory has one cycle of registered-address latency, so each returned word
// is paired with the PC that was issued on the previous edge. Pairs go to decode
// over a valid/ready handshake. A one-entry skid buffer (HOLD state) captures the
// memory output under backpressure, and a redirect port squashes in-flight work.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem_addr       read address to instruction memory (current fetch PC)
//   imem_insn       memory data for the address presented on the previous edge
//   out_valid/ready handshake to decode
//   out_insn/pc     instruction and its PC
//   redirect_valid  load redirect_pc as the new fetch PC, squash in-flight fetch
//   redirect_pc     redirect target (low offset bits ignored)
//
// Optional feature (macro FETCH_PERF_CNT_EN): adds saturating 32-bit counters
//   perf_fetch_cnt (transfers) and perf_stall_cnt (valid && !ready cycles).

module fetch_unit #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            INSN_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned            INSN_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INSN_WIDTH-1:0] imem_insn,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INSN_WIDTH-1:0] out_insn,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(INSN_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(PC_INC - 1'b1);

    typedef enum logic {StRun, StHold} state_e;

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_req_pc;
    logic                  r_req_valid;
    logic [INSN_WIDTH-1:0] r_hold_insn;
    logic [ADDR_WIDTH-1:0] r_hold_pc;

    logic                  w_valid;
    logic [INSN_WIDTH-1:0] w_insn;
    logic [ADDR_WIDTH-1:0] w_pc;
    logic                  w_xfer;

    assign imem_addr = r_pc;

    // Data is zeroed whenever the pair is not valid so reset and squash cycles
    // never expose stale memory output.
    always_comb begin
        w_valid = 1'b0;
        w_insn  = '0;
        w_pc    = '0;
        if (!rst && !redirect_valid) begin
            if (r_state == StHold) begin
                w_valid = 1'b1;
                w_insn  = r_hold_insn;
                w_pc    = r_hold_pc;
            end else if (r_req_valid) begin
                w_valid = 1'b1;
                w_insn  = imem_insn;
                w_pc    = r_req_pc;
            end
        end
    end

    assign out_valid = w_valid;
    assign out_insn  = w_insn;
    assign out_pc    = w_pc;
    // w_valid already excludes redirect cycles.
    assign w_xfer    = w_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StRun;
            r_pc        <= RESET_PC;
            r_req_pc    <= '0;
            r_req_valid <= 1'b0;
            r_hold_insn <= '0;
            r_hold_pc   <= '0;
        end else if (redirect_valid) begin
            // Squash the in-flight read and any held pair.
            r_state     <= StRun;
            r_pc        <= redirect_pc & ALIGN_MASK;
            r_req_valid <= 1'b0;
        end else begin
            case (r_state)
                StRun: begin
                    if (!r_req_valid || w_xfer) begin
                        r_pc        <= r_pc + PC_INC;
                        r_req_pc    <= r_pc;
                        r_req_valid <= 1'b1;
                    end else begin
                        // Memory output is only valid this cycle; park it.
                        r_hold_insn <= imem_insn;
                        r_hold_pc   <= r_req_pc;
                        r_state     <= StHold;
                    end
                end
                StHold: begin
                    // r_pc was held, so memory is already re-reading it.
                    if (w_xfer) begin
                        r_pc        <= r_pc + PC_INC;
                        r_req_pc    <= r_pc;
                        r_req_valid <= 1'b1;
                        r_state     <= StRun;
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_xfer && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_insn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_unit #(
        .ADDR_WIDTH (32),
        .INSN_WIDTH (32),
        .RESET_PC   (32'h0),
        .INSN_BYTES (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_insn      (imem_insn),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_insn       (out_insn),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word k lives at address 4k, one-cycle registered read.
    always_ff @(posedge clk) imem_insn <= imem_addr >> 2;

    int n_cmp;
    int n_fail;

    // Reference model: the next pair decode should see, plus cycle history.
    logic [31:0] exp_pc;
    bit          prev_rst;
    bit          prev_rd;
    logic [31:0] prev_rpc;
    bit          perf_known;
    int unsigned m_fetch;
    int unsigned m_stall;

    // Observations captured at the sample point of the latest step.
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_insn;
    logic [31:0] obs_addr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] obs_fetch;
    logic [31:0] obs_stall;
`endif

    typedef struct {
        bit          r;
        bit          rdy;
        bit          rd;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] einsn;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit rdy, input bit rd, input logic [31:0] rpc,
                       input bit ev, input logic [31:0] epc, input logic [31:0] einsn);
        vec_t v;
        v.r = r; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.einsn = einsn;
        vq.push_back(v);
    endtask

    // One clock cycle: drive inputs, sample at negedge, check against the model.
    task automatic step(input bit r, input bit rdy, input bit rd, input logic [31:0] rpc);
        bit exp_valid;
        rst            = r;
        out_ready      = rdy;
        redirect_valid = rd;
        redirect_pc    = rpc;
        @(negedge clk);
        obs_valid = out_valid;
        obs_pc    = out_pc;
        obs_insn  = out_insn;
        obs_addr  = imem_addr;
`ifdef FETCH_PERF_CNT_EN
        obs_fetch = perf_fetch_cnt;
        obs_stall = perf_stall_cnt;
`endif
        // A pair is offered unless this or the previous cycle was reset/redirect.
        exp_valid = !r && !rd && !prev_rst && !prev_rd;
        check("m_valid", {63'd0, out_valid}, {63'd0, exp_valid});
        if (exp_valid) begin
            check("m_pc", {32'd0, out_pc}, {32'd0, exp_pc});
            check("m_insn", {32'd0, out_insn}, {32'd0, exp_pc >> 2});
            check("m_addr", {32'd0, imem_addr}, {32'd0, exp_pc + 32'd4});
        end
        if (r) begin
            check("m_rst_pc", {32'd0, out_pc}, 64'd0);
            check("m_rst_insn", {32'd0, out_insn}, 64'd0);
        end
        if (prev_rst) check("m_addr_rst", {32'd0, imem_addr}, 64'd0);
        else if (prev_rd) check("m_addr_redir", {32'd0, imem_addr}, {32'd0, prev_rpc & ~32'd3});
`ifdef FETCH_PERF_CNT_EN
        if (perf_known) begin
            check("m_perf_fetch", {32'd0, perf_fetch_cnt}, {32'd0, m_fetch});
            check("m_perf_stall", {32'd0, perf_stall_cnt}, {32'd0, m_stall});
        end
`endif
        if (r) begin
            exp_pc     = 32'h0;
            m_fetch    = 0;
            m_stall    = 0;
            perf_known = 1'b1;
        end else if (rd) begin
            exp_pc = rpc & ~32'd3;
        end else if (exp_valid) begin
            if (rdy) begin
                exp_pc  = exp_pc + 32'd4;
                m_fetch = m_fetch + 1;
            end else begin
                m_stall = m_stall + 1;
            end
        end
        prev_rst = r;
        prev_rd  = rd;
        prev_rpc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        exp_pc = 32'h0; prev_rst = 1'b1; prev_rd = 1'b0; prev_rpc = 32'h0;
        perf_known = 1'b0; m_fetch = 0; m_stall = 0;
        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(posedge clk);
        #1;

        // Directed table: reset, stream, backpressure, redirects, wrap, reset in HOLD.
        add(1, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        add(1, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        add(0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        add(0, 1, 0, 32'h0, 1, 32'h0, 32'h0);
        add(0, 1, 0, 32'h0, 1, 32'h4, 32'h1);
        add(0, 0, 0, 32'h0, 1, 32'h8, 32'h2);
        add(0, 0, 0, 32'h0, 1, 32'h8, 32'h2);
        add(0, 0, 0, 32'h0, 1, 32'h8, 32'h2);
        add(0, 1, 0, 32'h0, 1, 32'h8, 32'h2);
        add(0, 1, 0, 32'h0, 1, 32'hC, 32'h3);
        add(0, 1, 1, 32'h103, 0, 32'h0, 32'h0);
        add(0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        add(0, 1, 0, 32'h0, 1, 32'h100, 32'h40);
        add(0, 0, 0, 32'h0, 1, 32'h104, 32'h41);
        add(0, 0, 1, 32'h40, 0, 32'h0, 32'h0);
        add(0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        add(0, 1, 0, 32'h0, 1, 32'h40, 32'h10);
        add(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
        add(0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        add(0, 1, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
        add(0, 1, 0, 32'h0, 1, 32'h0, 32'h0);
        add(0, 0, 0, 32'h0, 1, 32'h4, 32'h1);
        add(0, 0, 1'b0, 32'h0, 1, 32'h4, 32'h1);
        add(1, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        add(0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        add(0, 1, 0, 32'h0, 1, 32'h0, 32'h0);
        add(0, 1, 0, 32'h0, 1, 32'h4, 32'h1);

        foreach (vq[i]) begin
            step(vq[i].r, vq[i].rdy, vq[i].rd, vq[i].rpc);
            check($sformatf("t%0d_valid", i), {63'd0, obs_valid}, {63'd0, vq[i].ev});
            if (vq[i].ev) begin
                check($sformatf("t%0d_pc", i), {32'd0, obs_pc}, {32'd0, vq[i].epc});
                check($sformatf("t%0d_insn", i), {32'd0, obs_insn}, {32'd0, vq[i].einsn});
                check($sformatf("t%0d_addr", i), {32'd0, obs_addr}, {32'd0, vq[i].epc + 32'd4});
            end
        end

        // Randomized traffic against the model, including targets near the wrap.
        for (int c = 0; c < 3000; c++) begin
            bit          r;
            bit          rd;
            bit          rdy;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) == 0);
            rd  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else rpc = $urandom;
            step(r, rdy, rd, rpc);
        end

`ifdef FETCH_PERF_CNT_EN
        // 5 transfers and 3 stall cycles, then reset clears both counters.
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        check("perf_fetch_5", {32'd0, obs_fetch}, 64'd5);
        check("perf_stall_3", {32'd0, obs_stall}, 64'd3);
        step(0, 1, 0, 32'h0);
        check("perf_fetch_clr", {32'd0, obs_fetch}, 64'd0);
        check("perf_stall_clr", {32'd0, obs_stall}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
